// File: rtl/serial_sub8.sv
// Bit-serial subtractor: D = A - B, one bit per clock, LSB first.
// A single full-adder cell adds A to the inverted subtrahend with an
// initial carry of 1. Reports borrow (unsigned A < B) and signed overflow.
//
// Handshake: start is a request sampled only while idle (busy=0). Once it
// is taken, busy stays high for WIDTH+1 cycles. done pulses for one cycle
// on the last of them, and d/bo/v are valid from that cycle until the next
// done. Requests seen while busy are dropped, not queued.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             v,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  // One full-adder cell: minuend bit + inverted subtrahend bit + carry
  logic nb;
  logic sum_bit;
  logic carry_nxt;
  assign nb        = ~sb[0];
  assign sum_bit   = sa[0] ^ nb ^ carry;
  assign carry_nxt = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: idle waits for start, run walks WIDTH bits, done lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on start, shift one bit per RUN cycle, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b1;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        S_RUN: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          res   <= {sum_bit, res[WIDTH-1:1]};
          carry <= carry_nxt;
          // Counter parks at the terminal count instead of wrapping
          if (cnt != LAST) cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            d  <= {sum_bit, res[WIDTH-1:1]};
            bo <= ~carry_nxt;
            // Overflow only when operand signs differ and the result sign follows b
            v  <= (a_msb != b_msb) && (sum_bit != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and randomized bench for serial_sub8 with a result scoreboard.
module tb_serial_sub8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bo;
  logic       v;
  logic [1:0] dbg_state;

  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ops      = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a_in),
    .b         (b_in),
    .busy      (busy),
    .done      (done),
    .d         (d),
    .bo        (bo),
    .v         (v),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {difference, borrow, signed overflow}
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] dd;
    int r;
    dd = x - y;
    r  = int'($signed(x)) - int'($signed(y));
    return {dd, (x < y), ((r > 127) || (r < -128))};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called one sample after the start edge; waits for done and checks timing
  task automatic wait_done;
    int k;
    int bc;
    k  = 0;
    bc = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) bc++;
      step;
      k++;
    end
    if (busy === 1'b1) bc++;
    check("latency", k, 8);
    step;
    check("busy_after_done", {31'd0, busy}, 0);
    check("busy_cycles", bc, 9);
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    ops++;
    step;
    start = 1'b0;
    wait_done;
  endtask

  // Scoreboard monitor: every done pulse pops one expected result
  always begin
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_seen++;
      check("done_single_pulse", {31'd0, prev_done}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", exp_q.size(), 1);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("d", d, e[9:2]);
        check("bo", bo, e[1]);
        check("v", v, e[0]);
      end
    end
    prev_done = done;
  end

  initial begin
    int dcount;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    step;
    step;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_v", v, 0);
    rst = 1'b0;
    step;

    // Directed cases
    run_op(8'd100, 8'd37);
    run_op(8'd5, 8'd10);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'hFF);

    // Back-to-back: start held through RUN/DONE, operands change after the start edge
    a_in  = 8'hAA;
    b_in  = 8'hAA;
    start = 1'b1;
    exp_q.push_back(model(8'hAA, 8'hAA));
    ops++;
    step;
    a_in = 8'h3C;
    b_in = 8'h5A;
    wait_done;
    // Now idle with start still high: the next edge takes the new operands
    exp_q.push_back(model(8'h3C, 8'h5A));
    ops++;
    step;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done;

    // Reset in the middle of an operation
    a_in  = 8'd200;
    b_in  = 8'd50;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    check("abort_v", v, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dcount++;
      step;
    end
    check("abort_no_done", dcount, 0);
    run_op(8'd200, 8'd50);

    // Corners
    run_op(8'h00, 8'h00);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'h00);
    run_op(8'h80, 8'h7F);
    run_op(8'h7F, 8'h80);
    run_op(8'hFF, 8'hFF);

    // Random sample of the operand space
    for (int i = 0; i < 1500; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      // Occasionally leave an idle gap between operations
      if ($urandom_range(0, 3) == 0) step;
    end

    step;
    check("done_count", done_seen, ops);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
